// File: rtl/shift_rows_pipe_if.sv
// rtl/shift_rows_pipe_if.sv - handshake bundle for the shift_rows_pipe datapath
//
// Purpose: carries the input and output valid/ready streams of shift_rows_pipe.
// Ports (signals):
//   in_valid, in_dec, in_data   producer -> block
//   in_ready                    block -> producer
//   out_valid, out_data         block -> consumer
//   out_ready                   consumer -> block
// State vectors are [0:32*NB-1]; byte k is bits [8k +: 8], row k%4, column k/4.
// Modports: master is the environment side, slave is the shift_rows_pipe side.

interface shift_rows_pipe_if #(
  parameter int NB = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_dec;
  logic [0:32*NB-1]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [0:32*NB-1]  out_data;

  modport master (
    output in_valid, in_dec, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_dec, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - pipelined Rijndael ShiftRows / InvShiftRows unit
//
// Purpose: permutes the rows of an NB-column state (NB = 4, 6 or 8) left by
// S(r) (dec=0) or right by S(r) (dec=1), then carries the result through
// PIPE_STAGES (1 or 2) valid/ready register stages.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears every stage valid bit
//   bus        shift_rows_pipe_if.slave: in_valid/in_ready/in_dec/in_data,
//              out_valid/out_ready/out_data
//   cnt_clr    (SHIFT_ROWS_PIPE_CNT_EN only) zero the transfer counter
//   xfer_cnt   (SHIFT_ROWS_PIPE_CNT_EN only) count of output handshakes
// Optional feature macro: SHIFT_ROWS_PIPE_CNT_EN.
// The bus interface must be instantiated with the same NB as this module.

module shift_rows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef SHIFT_ROWS_PIPE_CNT_EN
  input  logic        cnt_clr,
  output logic [31:0] xfer_cnt,
`endif
  shift_rows_pipe_if.slave bus
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  if (!(PIPE_STAGES == 1 || PIPE_STAGES == 2)) begin : g_bad_pipe
    $error("shift_rows_pipe: PIPE_STAGES must be 1 or 2");
  end

  // Row offsets: {0,1,2,3} for NB=4/6, {0,1,3,4} for NB=8.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // Combinational permutation on the stage-1 input.
  logic [0:W-1] perm;

  always_comb begin
    perm = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (bus.in_dec)
          perm[8*(4*c+r) +: 8] = bus.in_data[8*(4*((c - row_shift(r) + NB) % NB) + r) +: 8];
        else
          perm[8*(4*c+r) +: 8] = bus.in_data[8*(4*((c + row_shift(r)) % NB) + r) +: 8];
      end
    end
  end

  // Stage 1: holds the permuted state.
  logic         v1;
  logic         r1;
  logic [0:W-1] d1;

  always_ff @(posedge clk) begin
    if (rst)
      v1 <= 1'b0;
    else if (r1)
      v1 <= bus.in_valid;
  end

  // Data flops carry no reset; they only load on an accepted transfer.
  always_ff @(posedge clk) begin
    if (r1 && bus.in_valid)
      d1 <= perm;
  end

  if (PIPE_STAGES == 1) begin : g_one
    assign r1            = !v1 || bus.out_ready;
    assign bus.out_valid = v1;
    assign bus.out_data  = d1;
  end else begin : g_two
    logic         v2;
    logic         r2;
    logic [0:W-1] d2;

    // Stage 1 may load whenever stage 2 can take its content, which collapses
    // a bubble in stage 1 even while the output is stalled.
    assign r2 = !v2 || bus.out_ready;
    assign r1 = !v1 || r2;

    always_ff @(posedge clk) begin
      if (rst)
        v2 <= 1'b0;
      else if (r2)
        v2 <= v1;
    end

    always_ff @(posedge clk) begin
      if (r2 && v1)
        d2 <= d1;
    end

    assign bus.out_valid = v2;
    assign bus.out_data  = d2;
  end

  // Held high during reset so upstream sees the block as ready immediately.
  assign bus.in_ready = r1 || rst;

`ifdef SHIFT_ROWS_PIPE_CNT_EN
  // Clear has priority over a same-cycle increment; the count wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr)
      xfer_cnt <= '0;
    else if (bus.out_valid && bus.out_ready)
      xfer_cnt <= xfer_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - self-checking bench for shift_rows_pipe

module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  shift_rows_pipe_if #(.NB(4)) ia ();
  shift_rows_pipe_if #(.NB(8)) ib ();
  shift_rows_pipe_if #(.NB(6)) ic ();

`ifdef SHIFT_ROWS_PIPE_CNT_EN
  logic        clr_a, clr_b, clr_c;
  logic [31:0] cnt_a, cnt_b, cnt_c;
`endif

  shift_rows_pipe #(.NB(4), .PIPE_STAGES(2)) dut_a (
    .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    .cnt_clr(clr_a), .xfer_cnt(cnt_a),
`endif
    .bus(ia)
  );

  shift_rows_pipe #(.NB(8), .PIPE_STAGES(1)) dut_b (
    .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    .cnt_clr(clr_b), .xfer_cnt(cnt_b),
`endif
    .bus(ib)
  );

  shift_rows_pipe #(.NB(6), .PIPE_STAGES(1)) dut_c (
    .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    .cnt_clr(clr_c), .xfer_cnt(cnt_c),
`endif
    .bus(ic)
  );

  task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: split the state into rows, rotate each row as a queue, reassemble.
  function automatic logic [0:255] ref_shift(input logic [0:255] v, input int nb, input bit dec);
    logic [7:0]   row[$];
    logic [0:255] res = '0;
    int           offs[4];
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(v[8*(4*c+r) +: 8]);
      if (!dec) repeat (offs[r]) row.push_back(row.pop_front());
      else      repeat (offs[r]) row.push_front(row.pop_back());
      for (int c = 0; c < nb; c++) res[8*(4*c+r) +: 8] = row[c];
    end
    return res;
  endfunction

  function automatic logic [0:127] ref4(input logic [0:127] v, input bit dec);
    logic [0:255] r;
    r = ref_shift({v, 128'b0}, 4, dec);
    return r[0:127];
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One isolated transfer through dut_a; lat counts negedges from acceptance to out_valid.
  task automatic send_a(input logic [0:127] d, input bit dec, output logic [0:127] q, output int lat);
    int n;
    @(negedge clk);
    ia.in_valid = 1'b1;
    ia.in_data  = d;
    ia.in_dec   = dec;
    n = 0;
    while (!ia.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    ia.in_valid = 1'b0;
    lat = 1;
    while (!ia.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = ia.out_data;
  endtask

  initial begin
    logic [0:127] q, v, y, held;
    logic [0:255] vb, rb;
    logic [0:191] vc;
    logic [0:255] rc;
    logic [0:127] vec[8];
    logic [0:127] exp_q[$];
    int           lat, sent, got, hs;
    bit           stall_prev;

    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_dec = 1'b0; ia.in_data = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_dec = 1'b0; ib.in_data = '0; ib.out_ready = 1'b1;
    ic.in_valid = 1'b0; ic.in_dec = 1'b0; ic.in_data = '0; ic.out_ready = 1'b1;
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_int("reset_out_valid_a", int'(ia.out_valid), 0);
    check_int("reset_in_ready_a", int'(ia.in_ready), 1);
    check_int("reset_out_valid_b", int'(ib.out_valid), 0);
    check_int("reset_in_ready_c", int'(ic.in_ready), 1);
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    check_int("reset_cnt_a", int'(cnt_a), 0);
`endif

    // Known-answer vectors, NB=4, two register stages.
    send_a(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, q, lat);
    check_vec("kat_fwd", 256'(q), 256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    check_int("kat_fwd_latency", lat, 2);
    send_a(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, q, lat);
    check_vec("kat_inv", 256'(q), 256'(128'hd42711aee0bf98f1b8b45de51e415230));
    check_int("kat_inv_latency", lat, 2);

    // NB=8 and NB=6 with incrementing bytes, one register stage.
    for (int k = 0; k < 32; k++) vb[8*k +: 8] = 8'(k);
    for (int k = 0; k < 24; k++) vc[8*k +: 8] = 8'(k);
    @(negedge clk);
    ib.in_valid = 1'b1; ib.in_data = vb; ib.in_dec = 1'b0;
    ic.in_valid = 1'b1; ic.in_data = vc; ic.in_dec = 1'b0;
    #1;
    check_int("nb8_in_ready", int'(ib.in_ready), 1);
    @(negedge clk);
    ib.in_valid = 1'b0;
    ic.in_valid = 1'b0;
    #1;
    rb = ref_shift(vb, 8, 1'b0);
    rc = ref_shift({vc, 64'b0}, 6, 1'b0);
    check_int("nb8_out_valid", int'(ib.out_valid), 1);
    check_vec("nb8_fwd", 256'(ib.out_data), 256'(rb));
    check_vec("nb8_first_col", 256'(ib.out_data[0:31]), 256'(32'h00050e13));
    check_vec("nb8_last_col", 256'(ib.out_data[224:255]), 256'(32'h1c010a0f));
    check_int("nb6_out_valid", int'(ic.out_valid), 1);
    check_vec("nb6_fwd", 256'(ic.out_data), 256'(rc[0:191]));
    check_vec("nb6_first_col", 256'(ic.out_data[0:31]), 256'(32'h00050a0f));
    ib.in_valid = 1'b1; ib.in_data = ib.out_data; ib.in_dec = 1'b1;
    ic.in_valid = 1'b1; ic.in_data = ic.out_data; ic.in_dec = 1'b1;
    @(negedge clk);
    ib.in_valid = 1'b0;
    ic.in_valid = 1'b0;
    #1;
    check_vec("nb8_roundtrip", 256'(ib.out_data), 256'(vb));
    check_vec("nb6_roundtrip", 256'(ic.out_data), 256'(vc));

    // Random round trips on NB=4.
    for (int i = 0; i < 1000; i++) begin
      v = rand128();
      send_a(v, 1'b0, y, lat);
      check_vec("rand_fwd", 256'(y), 256'(ref4(v, 1'b0)));
      send_a(y, 1'b1, q, lat);
      check_vec("rand_roundtrip", 256'(q), 256'(v));
    end

    // Stream of 8 alternating-direction transfers, output stalled on cycles 3..6.
    for (int i = 0; i < 8; i++) vec[i] = rand128();
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    held = '0;
    exp_q.delete();
    for (int t = 0; t < 60 && got < 8; t++) begin
      @(negedge clk);
      ia.out_ready = !(t >= 3 && t <= 6);
      ia.in_valid  = (sent < 8);
      if (sent < 8) begin
        ia.in_data = vec[sent];
        ia.in_dec  = sent[0];
      end
      #1;
      if (stall_prev) begin
        check_int("stall_valid_hold", int'(ia.out_valid), 1);
        check_vec("stall_data_hold", 256'(ia.out_data), 256'(held));
      end
      check_int("stream_in_ready", int'(ia.in_ready), int'(!(exp_q.size() == 2 && !ia.out_ready)));
      if (t == 4) check_int("stall_in_ready_low", int'(ia.in_ready), 0);
      if (ia.out_valid && ia.out_ready) begin
        check_int("stream_out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check_vec("stream_order", 256'(ia.out_data), 256'(exp_q.pop_front()));
          got++;
        end
      end
      stall_prev = ia.out_valid && !ia.out_ready;
      held = ia.out_data;
      if (ia.in_valid && ia.in_ready) begin
        exp_q.push_back(ref4(vec[sent], sent[0]));
        sent++;
      end
    end
    @(negedge clk);
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    check_int("stream_sent", sent, 8);
    check_int("stream_got", got, 8);
    check_int("stream_leftover", exp_q.size(), 0);
    hs = 0;
    repeat (4) begin
      @(negedge clk);
      if (ia.out_valid) hs++;
    end
    check_int("stream_no_duplicate", hs, 0);

    // Reset with two transfers in flight.
    @(negedge clk);
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.in_data = rand128(); ia.in_dec = 1'b0;
    @(negedge clk);
    ia.in_data = rand128();
    @(negedge clk);
    ia.in_valid = 1'b0;
    #1;
    check_int("inflight_out_valid", int'(ia.out_valid), 1);
    check_int("inflight_in_ready", int'(ia.in_ready), 0);
    rst = 1'b1;
    #1;
    check_int("rst_in_ready_during", int'(ia.in_ready), 1);
    @(negedge clk);
    check_int("rst_out_valid", int'(ia.out_valid), 0);
    check_int("rst_in_ready", int'(ia.in_ready), 1);
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    check_int("rst_cnt_a", int'(cnt_a), 0);
`endif
    rst = 1'b0;
    ia.out_ready = 1'b1;
    v = rand128();
    send_a(v, 1'b1, q, lat);
    check_vec("post_rst_data", 256'(q), 256'(ref4(v, 1'b1)));
    check_int("post_rst_latency", lat, 2);
    hs = 1;
    repeat (5) begin
      @(negedge clk);
      if (ia.out_valid) hs++;
    end
    check_int("post_rst_single_output", hs, 1);
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    check_int("post_rst_cnt_a", int'(cnt_a), 1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    check_int("cnt_clr_a", int'(cnt_a), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
